// File: rtl/axis_testpattern_pkg.sv
// Shared types and pattern arithmetic for the AXI-Stream test pattern generator/checker pair.
// Pattern values are handled as sign-extended integers one bit wider than any supported tdata.
package axis_testpattern_pkg;

    typedef enum logic {
        StSync  = 1'b0,
        StCheck = 1'b1
    } state_e;

    localparam int unsigned PatMaxWidth = 64;
    localparam int unsigned PatExtWidth = PatMaxWidth + 1;

    typedef logic signed [PatExtWidth-1:0] pat_t;

    // Next pattern value: step forward, wrap to start once the sum passes the end value.
    function automatic pat_t nxt(pat_t v, pat_t incr, pat_t start, pat_t stop);
        pat_t sum;
        sum = v + incr;
        return (sum > stop) ? start : sum;
    endfunction

endpackage

// File: rtl/axis_ready_divider.sv
// Registered tready throttle: offers ready once per DIVIDER enabled cycles and holds it
// until a handshake consumes it.
module axis_ready_divider #(
    parameter int unsigned DIVIDER = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    input  logic tvalid,
    output logic tready
);

    localparam int unsigned CW = (DIVIDER > 1) ? $clog2(DIVIDER) : 1;
    localparam logic [CW-1:0] Last = CW'(DIVIDER - 1);

    logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
    logic          tready_q, tready_d;
    logic          hs;

    assign hs      = tvalid & tready_q;
    assign cnt_inc = (cnt_q == Last) ? '0 : cnt_q + CW'(1);

    always_comb begin
        cnt_d    = cnt_q;
        tready_d = tready_q;
        if (!enable) begin
            tready_d = 1'b0;
        end else if (tready_q) begin
            // Counter stays frozen while a ready offer is outstanding.
            if (hs) begin
                cnt_d    = cnt_inc;
                tready_d = (cnt_inc == '0);
            end
        end else if (cnt_q == '0) begin
            tready_d = 1'b1;
        end else begin
            cnt_d    = cnt_inc;
            tready_d = (cnt_inc == '0);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q    <= '0;
            tready_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            tready_q <= tready_d;
        end
    end

    assign tready = tready_q;

endmodule

// File: rtl/axis_testpattern_checker.sv
// AXI-Stream sink that locks onto the generator's counter pattern and checks every beat.
// Define AXIS_TESTPATTERN_CHECKER_CAPTURE_EN to capture the first mismatching beat.
module axis_testpattern_checker
    import axis_testpattern_pkg::*;
#(
    parameter int unsigned S00_AXIS_TDATA_WIDTH = 8,
    parameter int          COUNTER_START        = -10,
    parameter int          COUNTER_END          = 10,
    parameter int          COUNTER_INCR         = 1,
    parameter int unsigned DIVIDER              = 3,
    parameter int unsigned CNT_WIDTH            = 32
) (
    input  logic                            s_axis_aclk,
    input  logic                            s_axis_areset,
    input  logic                            enable,
    input  logic                            clear,
    input  logic [S00_AXIS_TDATA_WIDTH-1:0] s_axis_tdata,
    input  logic                            s_axis_tvalid,
    output logic                            s_axis_tready,
    output logic                            locked,
    output logic                            error,
    output logic [CNT_WIDTH-1:0]            error_count,
    output logic [CNT_WIDTH-1:0]            beat_count,
    output logic [CNT_WIDTH-1:0]            wrap_count,
    output logic [S00_AXIS_TDATA_WIDTH-1:0] err_got,
    output logic [S00_AXIS_TDATA_WIDTH-1:0] err_exp
);

    localparam int unsigned DW = S00_AXIS_TDATA_WIDTH;

    localparam pat_t StartExt = pat_t'(COUNTER_START);
    localparam pat_t EndExt   = pat_t'(COUNTER_END);
    localparam pat_t IncrExt  = pat_t'(COUNTER_INCR);

    localparam logic [DW-1:0] StartVal = StartExt[DW-1:0];
    localparam logic [DW-1:0] EndVal   = EndExt[DW-1:0];

    state_e          state_q, state_d;
    logic [DW-1:0]   exp_q;
    logic [DW-1:0]   nxt_data;
    logic            hs;
    logic            match;
    logic            beat_evt, mismatch_evt, wrap_evt, load_exp;
    logic            error_q;
    logic [CNT_WIDTH-1:0] error_count_q, beat_count_q, wrap_count_q;

    axis_ready_divider #(
        .DIVIDER (DIVIDER)
    ) u_ready_divider (
        .clk    (s_axis_aclk),
        .rst    (s_axis_areset),
        .enable (enable),
        .tvalid (s_axis_tvalid),
        .tready (s_axis_tready)
    );

    assign hs       = s_axis_tvalid & s_axis_tready;
    assign match    = (s_axis_tdata == exp_q);
    assign nxt_data = DW'(nxt(pat_t'($signed(s_axis_tdata)), IncrExt, StartExt, EndExt));

    always_ff @(posedge s_axis_aclk or posedge s_axis_areset) begin
        if (s_axis_areset) begin
            state_q <= StSync;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (clear) begin
            state_d = StSync;
        end else if (hs && state_q == StSync && s_axis_tdata == StartVal) begin
            state_d = StCheck;
        end
    end

    // A clear on the same edge as a handshake drops that beat from all statistics.
    always_comb begin
        locked       = 1'b0;
        beat_evt     = hs & ~clear;
        mismatch_evt = 1'b0;
        wrap_evt     = 1'b0;
        load_exp     = 1'b0;
        unique case (state_q)
            StSync: begin
                load_exp = beat_evt & (s_axis_tdata == StartVal);
            end
            StCheck: begin
                locked       = 1'b1;
                load_exp     = beat_evt;
                mismatch_evt = beat_evt & ~match;
                wrap_evt     = beat_evt & match & (s_axis_tdata == EndVal);
            end
            default: ;
        endcase
    end

    always_ff @(posedge s_axis_aclk or posedge s_axis_areset) begin
        if (s_axis_areset) begin
            exp_q         <= '0;
            error_q       <= 1'b0;
            error_count_q <= '0;
            beat_count_q  <= '0;
            wrap_count_q  <= '0;
        end else if (clear) begin
            exp_q         <= '0;
            error_q       <= 1'b0;
            error_count_q <= '0;
            beat_count_q  <= '0;
            wrap_count_q  <= '0;
        end else begin
            if (load_exp) begin
                exp_q <= nxt_data;
            end
            if (beat_evt) begin
                beat_count_q <= beat_count_q + CNT_WIDTH'(1);
            end
            if (wrap_evt) begin
                wrap_count_q <= wrap_count_q + CNT_WIDTH'(1);
            end
            if (mismatch_evt) begin
                error_q <= 1'b1;
                if (error_count_q != '1) begin
                    error_count_q <= error_count_q + CNT_WIDTH'(1);
                end
            end
        end
    end

    assign error       = error_q;
    assign error_count = error_count_q;
    assign beat_count  = beat_count_q;
    assign wrap_count  = wrap_count_q;

`ifdef AXIS_TESTPATTERN_CHECKER_CAPTURE_EN
    logic [DW-1:0] got_cap_q, exp_cap_q;

    always_ff @(posedge s_axis_aclk or posedge s_axis_areset) begin
        if (s_axis_areset) begin
            got_cap_q <= '0;
            exp_cap_q <= '0;
        end else if (clear) begin
            got_cap_q <= '0;
            exp_cap_q <= '0;
        end else if (mismatch_evt && !error_q) begin
            got_cap_q <= s_axis_tdata;
            exp_cap_q <= exp_q;
        end
    end

    assign err_got = got_cap_q;
    assign err_exp = exp_cap_q;
`else
    assign err_got = '0;
    assign err_exp = '0;
`endif

endmodule

// File: tb/tb_axis_testpattern_checker.sv
// Randomized self-checking bench for axis_testpattern_checker against a beat-level reference model.
module tb_axis_testpattern_checker;

    localparam int DW    = 8;
    localparam int START = -10;
    localparam int STOP  = 10;
    localparam int INCR  = 1;
    localparam int DIV   = 3;
    localparam int CW    = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          enable;
    logic          clear;
    logic [DW-1:0] tdata;
    logic          tvalid;
    logic          tready;
    logic          locked;
    logic          error;
    logic [CW-1:0] error_count;
    logic [CW-1:0] beat_count;
    logic [CW-1:0] wrap_count;
    logic [DW-1:0] err_got;
    logic [DW-1:0] err_exp;

    always #5 clk = ~clk;

    axis_testpattern_checker #(
        .S00_AXIS_TDATA_WIDTH (DW),
        .COUNTER_START        (START),
        .COUNTER_END          (STOP),
        .COUNTER_INCR         (INCR),
        .DIVIDER              (DIV),
        .CNT_WIDTH            (CW)
    ) dut (
        .s_axis_aclk   (clk),
        .s_axis_areset (rst),
        .enable        (enable),
        .clear         (clear),
        .s_axis_tdata  (tdata),
        .s_axis_tvalid (tvalid),
        .s_axis_tready (tready),
        .locked        (locked),
        .error         (error),
        .error_count   (error_count),
        .beat_count    (beat_count),
        .wrap_count    (wrap_count),
        .err_got       (err_got),
        .err_exp       (err_exp)
    );

    int checks = 0;
    int errors = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Reference model: state of the checker described per accepted beat.
    bit m_locked, m_error;
    int m_exp, m_errcnt, m_beats, m_wraps, m_cap_got, m_cap_exp;

    function automatic int pat_next(int v);
        int s;
        s = v + INCR;
        return (s > STOP) ? START : s;
    endfunction

    function automatic void m_clear();
        m_locked = 0; m_error = 0; m_exp = 0;
        m_errcnt = 0; m_beats = 0; m_wraps = 0;
        m_cap_got = 0; m_cap_exp = 0;
    endfunction

    function automatic void m_accept(int d);
        m_beats++;
        if (!m_locked) begin
            if (d == START) begin
                m_locked = 1;
                m_exp    = pat_next(d);
            end
        end else if (d == m_exp) begin
            if (d == STOP) m_wraps++;
            m_exp = pat_next(d);
        end else begin
            if (!m_error) begin
                m_cap_got = d;
                m_cap_exp = m_exp;
            end
            m_error = 1;
            m_errcnt++;
            m_exp = pat_next(d);
        end
    endfunction

    task automatic compare_outputs();
        check_eq("locked", 64'(locked), 64'(m_locked));
        check_eq("error", 64'(error), 64'(m_error));
        check_eq("error_count", 64'(error_count), 64'(m_errcnt));
        check_eq("beat_count", 64'(beat_count), 64'(m_beats));
        check_eq("wrap_count", 64'(wrap_count), 64'(m_wraps));
`ifdef AXIS_TESTPATTERN_CHECKER_CAPTURE_EN
        check_eq("err_got", 64'(err_got), 64'(8'(m_cap_got)));
        check_eq("err_exp", 64'(err_exp), 64'(8'(m_cap_exp)));
`else
        check_eq("err_got", 64'(err_got), 64'(0));
        check_eq("err_exp", 64'(err_exp), 64'(0));
`endif
    endtask

    // Upstream source: generator value plus an AXIS-legal hold of the offered beat.
    int src;
    bit holding;
    bit adv;
    bit track;
    int low_run;

    task automatic offer(input int valid_pct, input int bad_pct);
        if (!holding) begin
            if ($urandom_range(99) < valid_pct) begin
                tvalid  = 1'b1;
                holding = 1;
                if ($urandom_range(99) < bad_pct) begin
                    tdata = 8'($urandom);
                    adv   = 0;
                end else begin
                    tdata = 8'(src);
                    adv   = 1;
                end
            end else begin
                tvalid = 1'b0;
            end
        end
    endtask

    task automatic step();
        bit hs, en, clr, prev;
        int d;
        hs   = tvalid && tready;
        en   = enable;
        clr  = clear;
        prev = tready;
        d    = int'($signed(tdata));
        @(posedge clk);
        #1;
        if (clr) m_clear();
        else if (hs) m_accept(d);
        if (hs) begin
            holding = 0;
            tvalid  = 1'b0;
            if (adv) src = pat_next(src);
        end
        // Ready must persist until consumed, then stay low for exactly DIV-1 cycles.
        if (!en) begin
            track = 0;
        end else begin
            if (prev && !hs) check_eq("ready_hold", 64'(tready), 64'(1));
            if (hs) begin
                track   = 1;
                low_run = 0;
            end
            if (track) begin
                if (!tready) low_run++;
                else begin
                    check_eq("ready_gap", 64'(low_run), 64'(DIV - 1));
                    track = 0;
                end
            end
        end
        compare_outputs();
    endtask

    int saved_beats;

    initial begin
        rst = 1'b1; enable = 1'b1; clear = 1'b0; tvalid = 1'b0; tdata = '0;
        holding = 0; adv = 0; track = 0; low_run = 0; src = START;
        m_clear();

        repeat (2) @(posedge clk);
        #1;
        compare_outputs();
        check_eq("rst_tready", 64'(tready), 64'(0));
        rst = 1'b0;
        #1;
        check_eq("rel_tready_low", 64'(tready), 64'(0));
        step();
        check_eq("rel_tready_high", 64'(tready), 64'(1));

        // Two clean periods with tvalid held high.
        for (int c = 0; c < 400 && m_beats < 42; c++) begin
            offer(100, 0);
            step();
        end
        check_eq("p1_beats", 64'(beat_count), 64'(42));
        check_eq("p1_wraps", 64'(wrap_count), 64'(2));
        check_eq("p1_locked", 64'(locked), 64'(1));
        check_eq("p1_error", 64'(error), 64'(0));

        // Clear, then an upstream starting mid-pattern at 3.
        clear = 1'b1;
        step();
        clear = 1'b0;
        src   = 3;
        for (int c = 0; c < 200 && m_beats < 8; c++) begin
            offer(100, 0);
            step();
        end
        check_eq("sync_discard_locked", 64'(locked), 64'(0));
        check_eq("sync_discard_beats", 64'(beat_count), 64'(8));
        for (int c = 0; c < 200 && m_beats < 9; c++) begin
            offer(100, 0);
            step();
        end
        check_eq("sync_lock", 64'(locked), 64'(1));
        check_eq("sync_errcnt", 64'(error_count), 64'(0));

        // Duplicate 5 where 6 belongs, then 6 must pass.
        for (int c = 0; c < 200 && !(src == 6 && !holding); c++) begin
            offer(100, 0);
            step();
        end
        tvalid = 1'b1; tdata = 8'(5); holding = 1; adv = 0;
        for (int c = 0; c < 20 && holding; c++) step();
        check_eq("inj_error", 64'(error), 64'(1));
        check_eq("inj_errcnt", 64'(error_count), 64'(1));
        offer(100, 0);
        for (int c = 0; c < 20 && holding; c++) step();
        check_eq("relock_errcnt", 64'(error_count), 64'(1));
`ifdef AXIS_TESTPATTERN_CHECKER_CAPTURE_EN
        check_eq("cap_got", 64'(err_got), 64'(5));
        check_eq("cap_exp", 64'(err_exp), 64'(6));
`endif

        // Random traffic: gaps, corrupt beats, upstream restarts, clear pulses.
        for (int c = 0; c < 3000; c++) begin
            if (!holding && $urandom_range(99) == 0) src = START;
            offer(60, 5);
            clear = ($urandom_range(99) == 0);
            step();
        end
        clear = 1'b0;

        // Idle with ready offered, then a disable window.
        for (int c = 0; c < 50 && (holding || !tready); c++) step();
        check_eq("idle_ready", 64'(tready), 64'(1));
        tvalid = 1'b0;
        repeat (4) step();
        check_eq("idle_hold", 64'(tready), 64'(1));
        saved_beats = m_beats;
        enable = 1'b0;
        step();
        check_eq("dis_drop", 64'(tready), 64'(0));
        for (int i = 0; i < 9; i++) step();
        check_eq("dis_low", 64'(tready), 64'(0));
        check_eq("dis_beats", 64'(beat_count), 64'(saved_beats));
        enable = 1'b1;
        step();
        check_eq("en_resume", 64'(tready), 64'(1));

        // Clear on the same edge as a handshake.
        tvalid = 1'b1; tdata = 8'(src); holding = 1; adv = 1;
        clear = 1'b1;
        step();
        clear = 1'b0;
        check_eq("clr_hs_beats", 64'(beat_count), 64'(0));
        check_eq("clr_hs_locked", 64'(locked), 64'(0));

        // Async reset while a beat is being offered.
        for (int c = 0; c < 30; c++) begin
            offer(100, 0);
            step();
        end
        for (int c = 0; c < 20 && !(tready && holding); c++) begin
            offer(100, 0);
            step();
        end
        check_eq("pre_rst_hs", 64'(tready && tvalid), 64'(1));
        #2;
        rst = 1'b1;
        #1;
        m_clear();
        holding = 0; tvalid = 1'b0; track = 0; src = START;
        compare_outputs();
        check_eq("arst_tready", 64'(tready), 64'(0));
        @(posedge clk);
        #1;
        rst = 1'b0;
        check_eq("arst_rel_low", 64'(tready), 64'(0));
        step();
        check_eq("arst_rel_high", 64'(tready), 64'(1));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
